// File: rtl/driver_pkg.sv
// Shared constants, derived widths and state type for the LED driver datapath
// (framebuffer_reader, driver_controller and the framebuffer emulator).
package driver_pkg;

  localparam int unsigned DRIVERS         = 30;
  localparam int unsigned POKER_MODE      = 9;
  localparam int unsigned CHANNELS        = 48;
  localparam int unsigned MUX_COUNT       = 8;
  localparam int unsigned BLANKING_CYCLES = 80;

  localparam int unsigned MUX_W   = $clog2(MUX_COUNT);
  localparam int unsigned BIT_W   = $clog2(POKER_MODE);
  localparam int unsigned CH_W    = $clog2(CHANNELS);
  localparam int unsigned BLANK_W = $clog2(BLANKING_CYCLES);
  localparam int unsigned ADDR_W  = 1 + MUX_W + BIT_W + CH_W;

  localparam int unsigned SLICE_CYCLES = BLANKING_CYCLES + POKER_MODE * CHANNELS;
  localparam int unsigned FRAME_CYCLES = SLICE_CYCLES * MUX_COUNT;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DATA
  } fb_state_t;

endpackage

// File: rtl/framebuffer_reader_if.sv
// Bit-plane RAM read port plus the poker-mode output stream of framebuffer_reader.
interface framebuffer_reader_if;
  import driver_pkg::*;

  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_rd;
  logic [DRIVERS-1:0] ram_q;
  logic [DRIVERS-1:0] framebuffer_dat;
  logic               framebuffer_sync;

  modport master (
    output ram_addr,
    output ram_rd,
    input  ram_q,
    output framebuffer_dat,
    output framebuffer_sync
  );

  modport slave (
    input  ram_addr,
    input  ram_rd,
    output ram_q,
    input  framebuffer_dat,
    input  framebuffer_sync
  );

endinterface

// File: rtl/framebuffer_reader.sv
// Sequences bit-plane reads from a double-buffered RAM and emits the 30-bit
// poker-mode stream with per-slice blanking, frame sync and buffer swapping.
module framebuffer_reader
  import driver_pkg::*;
(
  input  logic                 clk_hse,
  input  logic                 nrst,
  input  logic                 enable,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic                 display_buf,
  output logic                 busy,
  framebuffer_reader_if.master fb
);

  fb_state_t          state;
  fb_state_t          state_next;
  logic [BLANK_W-1:0] blank_cnt;
  logic [MUX_W-1:0]   mux_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [CH_W-1:0]    ch_cnt;
  logic               swap_pending;
  logic               blank_done;
  logic               slice_done;
  logic               frame_end;
  logic               first_word;
  logic               rd;
  logic               rd_d1;
  logic               sync_d1;

  assign blank_done = (blank_cnt == BLANK_W'(BLANKING_CYCLES - 1));
  assign slice_done = (state == DATA) && (bit_cnt == '0) && (ch_cnt == '0);
  assign frame_end  = slice_done && (mux_cnt == MUX_W'(MUX_COUNT - 1));
  assign first_word = (mux_cnt == '0) && (bit_cnt == BIT_W'(POKER_MODE - 1))
                      && (ch_cnt == CH_W'(CHANNELS - 1));

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (enable) state_next = BLANK;
      BLANK: if (blank_done) state_next = DATA;
      DATA: begin
        if (frame_end)       state_next = enable ? BLANK : IDLE;
        else if (slice_done) state_next = BLANK;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd          = 1'b0;
    busy        = 1'b1;
    fb.ram_addr = '0;
    case (state)
      IDLE: busy = 1'b0;
      DATA: begin
        rd          = 1'b1;
        fb.ram_addr = {display_buf, mux_cnt, bit_cnt, ch_cnt};
      end
      default: ;
    endcase
  end

  assign fb.ram_rd = rd;

  // bit/channel are preloaded during blanking so DATA starts at the top plane
  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      blank_cnt <= '0;
      mux_cnt   <= '0;
      bit_cnt   <= '0;
      ch_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          blank_cnt <= '0;
          mux_cnt   <= '0;
        end
        BLANK: begin
          blank_cnt <= blank_done ? '0 : blank_cnt + 1'b1;
          bit_cnt   <= BIT_W'(POKER_MODE - 1);
          ch_cnt    <= CH_W'(CHANNELS - 1);
        end
        DATA: begin
          if (ch_cnt == '0) begin
            ch_cnt  <= CH_W'(CHANNELS - 1);
            bit_cnt <= (bit_cnt == '0) ? BIT_W'(POKER_MODE - 1) : bit_cnt - 1'b1;
          end else begin
            ch_cnt <= ch_cnt - 1'b1;
          end
          if (frame_end)       mux_cnt <= '0;
          else if (slice_done) mux_cnt <= mux_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // a request landing on the frame-end cycle is folded into this boundary
  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      display_buf  <= 1'b0;
      swap_ack     <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (frame_end && (swap_pending || swap_req)) begin
        display_buf  <= ~display_buf;
        swap_ack     <= 1'b1;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      rd_d1               <= 1'b0;
      sync_d1             <= 1'b0;
      fb.framebuffer_dat  <= '0;
      fb.framebuffer_sync <= 1'b0;
    end else begin
      rd_d1               <= rd;
      sync_d1             <= rd && first_word;
      fb.framebuffer_dat  <= rd_d1 ? fb.ram_q : '0;
      fb.framebuffer_sync <= sync_d1;
    end
  end

endmodule

// File: tb/tb_framebuffer_reader.sv
// Self-checking bench for framebuffer_reader: positional reference model of the
// read sequence, scoreboard of expected output words two cycles downstream.
module tb_framebuffer_reader;
  import driver_pkg::*;

  typedef struct {
    logic [DRIVERS-1:0] dat;
    logic               sync;
  } exp_t;

  logic clk_hse  = 1'b0;
  logic nrst     = 1'b0;
  logic enable   = 1'b0;
  logic swap_req = 1'b0;
  logic swap_ack;
  logic display_buf;
  logic busy;

  framebuffer_reader_if fb_if();

  framebuffer_reader dut (
    .clk_hse    (clk_hse),
    .nrst       (nrst),
    .enable     (enable),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .display_buf(display_buf),
    .busy       (busy),
    .fb         (fb_if)
  );

  always #5 clk_hse = ~clk_hse;

  // RAM word = address; junk when not read so output gating is exercised
  always @(posedge clk_hse)
    fb_if.ram_q <= fb_if.ram_rd ? DRIVERS'(fb_if.ram_addr) : DRIVERS'($urandom);

  int   checks = 0;
  int   errors = 0;
  int   samp   = 0;
  int   mpos   = -1;
  int   en_drop_pos = -1;
  logic exp_buf = 1'b0;
  logic exp_pend = 1'b0;
  logic exp_ack = 1'b0;
  int   swap_at[$];
  exp_t sb[$];

  function automatic exp_t zero_exp();
    exp_t z;
    z.dat  = '0;
    z.sync = 1'b0;
    return z;
  endfunction

  task automatic model_restart();
    samp     = 0;
    mpos     = 0;
    exp_buf  = 1'b0;
    exp_pend = 1'b0;
    exp_ack  = 1'b0;
    en_drop_pos = -1;
    swap_at.delete();
    sb.delete();
    sb.push_back(zero_exp());
    sb.push_back(zero_exp());
  endtask

  task automatic run_cycles(input int n);
    logic exp_rd;
    logic fend;
    logic [ADDR_W-1:0] exp_addr;
    int o;
    int mux;
    int kk;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_hse);
      samp++;
      exp_rd = 1'b0; exp_addr = '0; fend = 1'b0; mux = 0; kk = 0;
      if (mpos >= 0) begin
        o    = mpos % SLICE_CYCLES;
        mux  = (mpos / SLICE_CYCLES) % MUX_COUNT;
        fend = (mux == MUX_COUNT - 1) && (o == SLICE_CYCLES - 1);
        if (o >= BLANKING_CYCLES) begin
          kk       = o - BLANKING_CYCLES;
          exp_rd   = 1'b1;
          exp_addr = {exp_buf, MUX_W'(mux), BIT_W'(POKER_MODE - 1 - kk / CHANNELS),
                      CH_W'(CHANNELS - 1 - kk % CHANNELS)};
        end
      end
      checks++;
      if (fb_if.ram_rd !== exp_rd) begin
        errors++; $display("FAIL ram_rd @%0d: got %b want %b", samp, fb_if.ram_rd, exp_rd);
      end
      checks++;
      if (fb_if.ram_addr !== exp_addr) begin
        errors++; $display("FAIL ram_addr @%0d: got %h want %h", samp, fb_if.ram_addr, exp_addr);
      end
      checks++;
      if (busy !== (mpos >= 0)) begin
        errors++; $display("FAIL busy @%0d: got %b want %b", samp, busy, (mpos >= 0));
      end
      checks++;
      if (swap_ack !== exp_ack) begin
        errors++; $display("FAIL swap_ack @%0d: got %b want %b", samp, swap_ack, exp_ack);
      end
      checks++;
      if (display_buf !== exp_buf) begin
        errors++; $display("FAIL display_buf @%0d: got %b want %b", samp, display_buf, exp_buf);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL scoreboard_empty @%0d: got 0 entries want >0", samp);
      end else begin
        e = sb.pop_front();
        if (fb_if.framebuffer_dat !== e.dat) begin
          errors++;
          $display("FAIL framebuffer_dat @%0d: got %h want %h", samp, fb_if.framebuffer_dat, e.dat);
        end
        checks++;
        if (fb_if.framebuffer_sync !== e.sync) begin
          errors++;
          $display("FAIL framebuffer_sync @%0d: got %b want %b", samp, fb_if.framebuffer_sync, e.sync);
        end
      end

      swap_req = 1'b0;
      if (mpos >= 0 && swap_at.size() != 0 && swap_at[0] == mpos) begin
        swap_req = 1'b1;
        void'(swap_at.pop_front());
      end
      if (mpos >= 0 && mpos == en_drop_pos) enable = 1'b0;

      e.dat  = exp_rd ? DRIVERS'(exp_addr) : '0;
      e.sync = exp_rd && (mux == 0) && (kk == 0);
      sb.push_back(e);

      exp_ack = 1'b0;
      if (mpos >= 0 && fend) begin
        if (exp_pend || swap_req) begin
          exp_buf  = ~exp_buf;
          exp_ack  = 1'b1;
          exp_pend = 1'b0;
        end
        mpos = enable ? mpos + 1 : -1;
      end else if (mpos >= 0) begin
        if (swap_req) exp_pend = 1'b1;
        mpos++;
      end else begin
        if (swap_req) exp_pend = 1'b1;
        if (enable) mpos = 0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_hse);
    checks++;
    if ({fb_if.ram_rd, fb_if.framebuffer_sync, busy, swap_ack, display_buf} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {fb_if.ram_rd, fb_if.framebuffer_sync, busy, swap_ack, display_buf});
    end
    checks++;
    if (fb_if.ram_addr !== '0) begin
      errors++; $display("FAIL reset_addr: got %h want 0", fb_if.ram_addr);
    end
    checks++;
    if (fb_if.framebuffer_dat !== '0) begin
      errors++; $display("FAIL reset_dat: got %h want 0", fb_if.framebuffer_dat);
    end
  endtask

  task automatic test_stream();
    logic [ADDR_W-1:0] first_addr;
    first_addr = {1'b0, MUX_W'(0), BIT_W'(POKER_MODE - 1), CH_W'(CHANNELS - 1)};
    nrst   = 1'b1;
    enable = 1'b1;
    model_restart();
    run_cycles(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_cycle1: got %b want 1", busy);
    end
    run_cycles(80);
    checks++;
    if (fb_if.ram_rd !== 1'b1 || fb_if.ram_addr !== first_addr) begin
      errors++;
      $display("FAIL first_read: got rd=%b addr=%h want rd=1 addr=%h", fb_if.ram_rd, fb_if.ram_addr, first_addr);
    end
    run_cycles(2);
    checks++;
    if (fb_if.framebuffer_sync !== 1'b1 || fb_if.framebuffer_dat !== DRIVERS'(first_addr)) begin
      errors++;
      $display("FAIL first_sync: got sync=%b dat=%h want sync=1 dat=%h",
               fb_if.framebuffer_sync, fb_if.framebuffer_dat, DRIVERS'(first_addr));
    end
  endtask

  task automatic test_swap_mid();
    swap_at.push_back(1000);
    run_cycles(FRAME_CYCLES + 1 - samp);
    checks++;
    if (swap_ack !== 1'b1 || display_buf !== 1'b1) begin
      errors++; $display("FAIL swap_mid: got ack=%b buf=%b want ack=1 buf=1", swap_ack, display_buf);
    end
    run_cycles(FRAME_CYCLES - 2);
  endtask

  task automatic test_swap_edge();
    swap_at.push_back(2 * FRAME_CYCLES - 1);
    swap_at.push_back(2 * FRAME_CYCLES + 100);
    swap_at.push_back(2 * FRAME_CYCLES + 2000);
    run_cycles(2);
    checks++;
    if (swap_ack !== 1'b1 || display_buf !== 1'b0) begin
      errors++; $display("FAIL swap_edge: got ack=%b buf=%b want ack=1 buf=0", swap_ack, display_buf);
    end
    run_cycles(FRAME_CYCLES);
    checks++;
    if (swap_ack !== 1'b1 || display_buf !== 1'b1) begin
      errors++; $display("FAIL swap_double: got ack=%b buf=%b want ack=1 buf=1", swap_ack, display_buf);
    end
  endtask

  task automatic test_enable_drop();
    en_drop_pos = 3 * FRAME_CYCLES + 3 * SLICE_CYCLES + 200;
    run_cycles(4 * FRAME_CYCLES + 40 - samp);
    checks++;
    if (busy !== 1'b0 || fb_if.ram_rd !== 1'b0 || fb_if.framebuffer_dat !== '0) begin
      errors++;
      $display("FAIL enable_drop_idle: got busy=%b rd=%b dat=%h want 0 0 0",
               busy, fb_if.ram_rd, fb_if.framebuffer_dat);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    mpos   = 0;
    en_drop_pos = -1;
    swap_at.push_back(100);
    run_cycles(5 * SLICE_CYCLES + 201);
    checks++;
    if (display_buf !== 1'b1 || fb_if.ram_rd !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got buf=%b rd=%b want buf=1 rd=1", display_buf, fb_if.ram_rd);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if ({fb_if.ram_rd, fb_if.framebuffer_sync, busy, swap_ack, display_buf} !== 5'b0
        || fb_if.ram_addr !== '0 || fb_if.framebuffer_dat !== '0) begin
      errors++;
      $display("FAIL reset_mid: got flags=%b addr=%h dat=%h want all 0",
               {fb_if.ram_rd, fb_if.framebuffer_sync, busy, swap_ack, display_buf},
               fb_if.ram_addr, fb_if.framebuffer_dat);
    end
    repeat (3) @(negedge clk_hse);
    nrst   = 1'b1;
    enable = 1'b1;
    model_restart();
    run_cycles(83);
    checks++;
    if (fb_if.framebuffer_sync !== 1'b1 || display_buf !== 1'b0) begin
      errors++;
      $display("FAIL restart_sync: got sync=%b buf=%b want sync=1 buf=0", fb_if.framebuffer_sync, display_buf);
    end
    run_cycles(FRAME_CYCLES + 1 - samp);
    checks++;
    if (swap_ack !== 1'b0 || display_buf !== 1'b0) begin
      errors++; $display("FAIL discarded_swap: got ack=%b buf=%b want ack=0 buf=0", swap_ack, display_buf);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_swap_mid();
    test_swap_edge();
    test_enable_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
